// File: rtl/e3_pkg.sv
// e3_pkg: shared Excess-3 constants, divider state encoding and digit check
package e3_pkg;
    localparam int E3_BIAS = 3;
    localparam logic [3:0] E3_DIGIT_MIN = 4'd3;
    localparam logic [3:0] E3_DIGIT_MAX = 4'd12;
    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
    function automatic logic e3_digit_ok(input logic [3:0] code);
        return code >= E3_DIGIT_MIN && code <= E3_DIGIT_MAX;
    endfunction
endpackage

// File: rtl/e3_div_step.sv
// e3_div_step: one combinational restoring-division step
//   r_in    partial remainder (always < divisor, so 4 bits suffice)
//   dvd_bit next dividend bit shifted in, MSB first
//   dvs     binary divisor 1..9
//   r_out   new partial remainder
//   q_bit   quotient bit produced by this step
module e3_div_step (
    input  logic [3:0] r_in,
    input  logic       dvd_bit,
    input  logic [3:0] dvs,
    output logic [3:0] r_out,
    output logic       q_bit
);
    logic [4:0] r_sh;
    assign r_sh  = {r_in, dvd_bit};
    assign q_bit = r_sh >= {1'b0, dvs};
    assign r_out = 4'(q_bit ? r_sh - {1'b0, dvs} : r_sh);
endmodule

// File: rtl/e3_div.sv
// e3_div: iterative Excess-3 dividend / Excess-3 digit divider with start/busy/done handshake
//   clk, rst     clock and synchronous active-high reset
//   start        request, sampled only in IDLE
//   in_dividend  Excess-3 dividend (value 0..DMAX)
//   in_divisor   Excess-3 divisor digit (value 1..9 legal)
//   quot, rem    Excess-3 results, held until the next accepted start
//   busy         high while a request is in flight
//   done         one-cycle result-valid pulse
//   err          illegal request flag, held with quot/rem
module e3_div
    import e3_pkg::*;
#(
    parameter int DW   = 8,
    parameter int DMAX = 81
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] in_dividend,
    input  logic [3:0]    in_divisor,
    output logic [DW-1:0] quot,
    output logic [3:0]    rem,
    output logic          busy,
    output logic          done,
    output logic          err
);
    localparam int CW = $clog2(DW);
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [DW-1:0] dvd, q;
    logic [3:0] dvs, r, r_nx;
    logic q_bit, bad, legal;
    // divisor code 3 is divide-by-zero, so the lowest legal code is one above the digit minimum
    assign legal = in_divisor != E3_DIGIT_MIN && e3_digit_ok(in_divisor)
                && in_dividend >= DW'(E3_BIAS) && in_dividend <= DW'(DMAX + E3_BIAS);
    e3_div_step u_step (
        .r_in   (r),
        .dvd_bit(dvd[cnt]),
        .dvs    (dvs),
        .r_out  (r_nx),
        .q_bit  (q_bit)
    );
    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE && start) ? (legal ? CALC : FIN)
                 : (state == CALC) ? (cnt == '0 ? FIN : CALC)
                 : (state == FIN) ? IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            quot  <= DW'(E3_BIAS);
            rem   <= 4'(E3_BIAS);
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            if (state == IDLE && start) begin
                dvd  <= in_dividend - DW'(E3_BIAS);
                dvs  <= in_divisor - 4'(E3_BIAS);
                bad  <= !legal;
                busy <= 1'b1;
                err  <= 1'b0;
                cnt  <= CW'(DW - 1);
                r    <= '0;
                q    <= '0;
            end
            if (state == CALC) begin
                r      <= r_nx;
                q[cnt] <= q_bit;
                cnt    <= cnt - 1'b1;
            end
            if (state == FIN) begin
                quot <= bad ? '1 : q + DW'(E3_BIAS);
                rem  <= bad ? 4'hF : r + 4'(E3_BIAS);
                err  <= bad;
                done <= 1'b1;
                busy <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_e3_div.sv
// tb_e3_div: directed and randomized checks of e3_div against an arithmetic model
module tb_e3_div;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [7:0] in_dividend = '0, quot;
    logic [3:0] in_divisor = '0, rem;
    logic busy, done, err;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    e3_div dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_dividend(in_dividend),
        .in_divisor (in_divisor),
        .quot       (quot),
        .rem        (rem),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request and check it against plain arithmetic.
    // poke > 0 re-pulses start with junk operands just before edge E<poke>.
    task automatic do_op(input logic [7:0] a, input logic [3:0] b, input int poke);
        int n;
        logic ok, bsy_ok;
        logic [7:0] eq;
        logic [3:0] er;
        ok = b >= 4 && b <= 12 && a >= 3 && a <= 84;
        eq = ok ? 8'((a - 3) / (b - 3) + 3) : 8'hFF;
        er = ok ? 4'((a - 3) % (b - 3) + 3) : 4'hF;
        in_dividend = a;
        in_divisor  = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        bsy_ok = 1'b1;
        while (!done && n < 20) begin
            if (!busy) bsy_ok = 1'b0;
            if (n + 1 == poke) begin
                start = 1'b1;
                in_dividend = 8'd84;
                in_divisor = 4'd4;
            end
            @(posedge clk);
            #1 start = 1'b0;
            n++;
        end
        chk($sformatf("latency a=%0d b=%0d", a, b), n, ok ? 9 : 1);
        chk("busy_while_running", bsy_ok, 1);
        chk($sformatf("quot a=%0d b=%0d", a, b), quot, eq);
        chk($sformatf("rem a=%0d b=%0d", a, b), rem, er);
        chk("err", err, !ok);
        chk("busy_at_done", busy, 0);
        @(posedge clk);
        #1 chk("done_one_cycle", done, 0);
    endtask

    initial begin
        int seen;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_quot", quot, 8'h03);
        chk("rst_rem", rem, 4'h3);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        do_op(8'd30, 4'd6, 0);
        do_op(8'd80, 4'd12, 0);
        do_op(8'd3, 4'd4, 0);
        do_op(8'd87, 4'd4, 0);
        do_op(8'd84, 4'd12, 0);
        do_op(8'd30, 4'd3, 0);
        do_op(8'd90, 4'd6, 0);
        do_op(8'd2, 4'd6, 0);
        do_op(8'd30, 4'd13, 0);
        do_op(8'd30, 4'd6, 0);
        do_op(8'd30, 4'd6, 3);
        chk("repulse_quot", quot, 8'd12);
        in_dividend = 8'd30;
        in_divisor = 4'd6;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_quot", quot, 8'h03);
        chk("midrst_rem", rem, 4'h3);
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1 if (done) seen++;
        end
        chk("midrst_no_done", seen, 0);
        do_op(8'd80, 4'd12, 0);
        for (int a = 3; a <= 84; a++)
            for (int b = 4; b <= 12; b++)
                do_op(8'(a), 4'(b), 0);
        repeat (60) do_op(8'($urandom_range(0, 95)), 4'($urandom_range(0, 15)), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
